// File: rtl/pla_pkg.sv
// Shared types and default sizes for the PLA OR-plane configuration path.
package pla_pkg;

    localparam int PLA_NUM_INPUTS  = 5;
    localparam int PLA_NUM_OUTPUTS = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETUP,
        STROBE,
        HOLD,
        DONE
    } pla_prog_state_t;

endpackage

// File: rtl/pla_onehot_dec.sv
// Index-to-one-hot decoder driving the per-cell write enables.
module pla_onehot_dec
    import pla_pkg::*;
#(
    parameter int NUM_OUTPUTS = PLA_NUM_OUTPUTS,
    parameter int IDX_W       = 2
)(
    input  logic [IDX_W-1:0]       idx,
    input  logic                   en,
    output logic [NUM_OUTPUTS-1:0] onehot
);

    always_comb begin
        onehot = '0;
        for (int i = 0; i < NUM_OUTPUTS; i++) begin
            onehot[i] = en && (idx == IDX_W'(i));
        end
    end

endmodule

// File: rtl/pla_or_programmer.sv
// Streams select words into the OR-plane cells, one cell at a time,
// keeping the select bus stable around every write-enable pulse.
module pla_or_programmer
    import pla_pkg::*;
#(
    parameter int NUM_INPUTS  = PLA_NUM_INPUTS,
    parameter int NUM_OUTPUTS = PLA_NUM_OUTPUTS,
    localparam int IDX_W = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1
)(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [NUM_INPUTS-1:0]  cfg_data,
    output logic [NUM_INPUTS-1:0]  sel_o,
    output logic [NUM_OUTPUTS-1:0] wen_o,
    output logic                   busy,
    output logic                   done,
    output logic [IDX_W-1:0]       cur_cell
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_OUTPUTS - 1);

    pla_prog_state_t         state, state_nx;
    logic [IDX_W-1:0]        idx, idx_nx;
    logic [NUM_INPUTS-1:0]   sel;
    logic                    load_sel;
    logic [NUM_OUTPUTS-1:0]  wen_dec;

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        load_sel = 1'b0;
        if (state != IDLE && abort) begin
            state_nx = IDLE;
            idx_nx   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state_nx = LOAD;
                        idx_nx   = '0;
                    end
                end
                LOAD: begin
                    if (cfg_valid) begin
                        state_nx = SETUP;
                        load_sel = 1'b1;
                    end
                end
                SETUP:  state_nx = STROBE;
                STROBE: state_nx = HOLD;
                HOLD: begin
                    if (idx == LAST) begin
                        state_nx = DONE;
                    end else begin
                        state_nx = LOAD;
                        idx_nx   = idx + 1'b1;
                    end
                end
                DONE: begin
                    state_nx = IDLE;
                    idx_nx   = '0;
                end
                default: begin
                    state_nx = IDLE;
                    idx_nx   = '0;
                end
            endcase
        end
    end

    // Decode from the next state so the enable is a clean flop output in STROBE.
    pla_onehot_dec #(
        .NUM_OUTPUTS (NUM_OUTPUTS),
        .IDX_W       (IDX_W)
    ) u_dec (
        .idx    (idx_nx),
        .en     (state_nx == STROBE),
        .onehot (wen_dec)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            sel   <= '0;
            wen_o <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
            wen_o <= wen_dec;
            if (load_sel) begin
                sel <= cfg_data;
            end
        end
    end

    assign sel_o     = sel;
    assign cfg_ready = (state == LOAD);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign cur_cell  = idx;

endmodule

// File: tb/tb_pla_or_programmer.sv
// Randomized bench for pla_or_programmer against a cycle-schedule model
// and a model of the OR cells capturing sel_o on each write-enable rise.
module tb_pla_or_programmer;
    import pla_pkg::*;

    localparam int NI = PLA_NUM_INPUTS;
    localparam int NO = PLA_NUM_OUTPUTS;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          cfg_valid = 1'b0;
    logic [NI-1:0] cfg_data = '0;
    logic          cfg_ready;
    logic [NI-1:0] sel_o;
    logic [NO-1:0] wen_o;
    logic          busy;
    logic          done;
    logic [1:0]    cur_cell;

    logic          start1 = 1'b0;
    logic          abort1 = 1'b0;
    logic          valid1 = 1'b1;
    logic [NI-1:0] data1 = 5'h15;
    logic          ready1;
    logic [NI-1:0] sel1;
    logic [0:0]    wen1;
    logic          busy1;
    logic          done1;
    logic [0:0]    cell1;

    int checks = 0;
    int failures = 0;

    logic [NI-1:0] words [NO];
    logic [NI-1:0] cells [NO];
    logic [NO-1:0] prev_wen = '0;

    always #5 clk = ~clk;

    pla_or_programmer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_data  (cfg_data),
        .sel_o     (sel_o),
        .wen_o     (wen_o),
        .busy      (busy),
        .done      (done),
        .cur_cell  (cur_cell)
    );

    pla_or_programmer #(.NUM_INPUTS(NI), .NUM_OUTPUTS(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start1),
        .abort     (abort1),
        .cfg_valid (valid1),
        .cfg_ready (ready1),
        .cfg_data  (data1),
        .sel_o     (sel1),
        .wen_o     (wen1),
        .busy      (busy1),
        .done      (done1),
        .cur_cell  (cell1)
    );

    // OR cells: each captures the select bus on the rise of its enable.
    always @(wen_o) begin
        for (int i = 0; i < NO; i++) begin
            if (wen_o[i] && !prev_wen[i]) cells[i] = sel_o;
        end
        prev_wen = wen_o;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic rand_words();
        for (int i = 0; i < NO; i++) words[i] = NI'($urandom);
    endtask

    // gcell/glen: LOAD stall before a word; acell: abort in that cell's STROBE;
    // poke: cycle of a stray start while busy (0 = none).
    task automatic run_pass(input int gcell, input int glen,
                            input int acell, input int poke);
        int l [NO];
        int a [NO];
        int s [NO];
        int d, last, k, ecell;
        bit live, erdy;
        logic [NO-1:0] ewen;
        for (int i = 0; i < NO; i++) begin
            l[i] = (i == 0) ? 1 : a[i-1] + 4;
            a[i] = l[i] + ((i == gcell) ? glen : 0);
            s[i] = a[i] + 2;
        end
        d = a[NO-1] + 4;
        last = (acell >= 0) ? s[acell] + 1 : d + 1;
        start = 1'b1;
        cfg_valid = 1'b1;
        cfg_data = NI'($urandom);
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 1; c <= last + 2; c++) begin
            live = (acell >= 0) ? (c <= s[acell]) : (c <= d);
            ewen = '0;
            ecell = 0;
            erdy = 1'b0;
            for (int i = 0; i < NO; i++) begin
                if (acell < 0 || i <= acell) begin
                    if (c == s[i]) ewen[i] = 1'b1;
                    if (c >= s[i] - 1 && c <= s[i] + 1)
                        check("sel", 32'(sel_o), 32'(words[i]));
                end
                if (live && l[i] <= c) ecell = i;
                if (live && c >= l[i] && c <= a[i]) erdy = 1'b1;
            end
            check("wen", 32'(wen_o), 32'(ewen));
            check("done", 32'(done), 32'(acell < 0 && c == d));
            check("busy", 32'(busy), 32'(live));
            check("cur_cell", 32'(cur_cell), 32'(ecell));
            check("ready", 32'(cfg_ready), 32'(erdy));
            abort = (acell >= 0 && c == s[acell]);
            start = (poke != 0 && c == poke);
            k = NO;
            for (int i = NO - 1; i >= 0; i--) begin
                if (a[i] >= c) k = i;
            end
            if (k < NO) begin
                cfg_valid = !(c >= l[k] && c < a[k]);
                cfg_data = words[k];
            end else begin
                cfg_valid = 1'b1;
                cfg_data = NI'($urandom);
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        abort = 1'b0;
        cfg_valid = 1'b0;
        for (int i = 0; i < NO; i++) begin
            if (acell < 0 || i <= acell)
                check("or_cell", 32'(cells[i]), 32'(words[i]));
        end
    endtask

    initial begin
        int gc, gl, ac, pk;
        repeat (2) @(posedge clk);
        #1;
        check("rst_sel", 32'(sel_o), 0);
        check("rst_wen", 32'(wen_o), 0);
        check("rst_ready", 32'(cfg_ready), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_cell", 32'(cur_cell), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        words[0] = 5'h03;
        words[1] = 5'h1C;
        words[2] = 5'h11;
        words[3] = 5'h0A;
        run_pass(-1, 0, -1, 0);

        rand_words();
        run_pass(2, 10, -1, 0);

        rand_words();
        run_pass(-1, 0, 1, 0);
        rand_words();
        run_pass(-1, 0, -1, 0);

        rand_words();
        run_pass(-1, 0, -1, 4);

        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            check("n1_wen", 32'(wen1), 32'(c == 3));
            check("n1_done", 32'(done1), 32'(c == 5));
            check("n1_busy", 32'(busy1), 32'(c <= 5));
            if (c == 3) check("n1_sel", 32'(sel1), 32'h15);
            @(posedge clk);
            #1;
        end

        for (int p = 0; p < 6; p++) begin
            rand_words();
            gc = int'($urandom_range(0, NO - 1));
            gl = int'($urandom_range(0, 6));
            ac = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, NO - 1)) : -1;
            pk = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 3)) : 0;
            run_pass(gc, gl, ac, pk);
        end

        rand_words();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cfg_valid = 1'b1;
        cfg_data = words[0];
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("ar_strobe", 32'(wen_o), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_wen", 32'(wen_o), 0);
        check("ar_busy", 32'(busy), 0);
        check("ar_sel", 32'(sel_o), 0);
        #10;
        rst_n = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
            check("ar_idle_busy", 32'(busy), 0);
            check("ar_idle_wen", 32'(wen_o), 0);
            check("ar_idle_sel", 32'(sel_o), 0);
        end
        check("ar_cell0", 32'(cells[0]), 32'(words[0]));
        cfg_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
